// File: rtl/arm_mem_pkg.sv
// Shared state type, widths and default base address for the ARM data-memory
// to 16-bit SRAM bridge.
package arm_mem_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int WORD_IDX_W  = SRAM_ADDR_W - 1;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } mem_state_e;

  // Byte offset of a pipeline address from the start of the SRAM window.
  function automatic logic [31:0] sram_offset(input logic [31:0] address,
                                              input logic [31:0] base);
    return address - base;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-half-word wait counter: counts cycles spent in one SRAM access phase and
// flags the last one.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic done
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 4'd1;
    end
  end

  assign done = (count == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit pipeline load/store into two half-word SRAM accesses.
// Optional macro SRAM_RANGE_CHECK_EN rejects out-of-window or unaligned addresses.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic                   addr_err,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_we_n
);

  mem_state_e            state;
  logic                  is_write;
  logic [31:0]           data_q;
  logic [WORD_IDX_W-1:0] idx_q;

  logic                  req;
  logic                  addr_ok;
  logic                  cnt_clear;
  logic                  cnt_en;
  logic                  cnt_done;
  logic [31:0]           offset;
  logic [WORD_IDX_W-1:0] req_idx;

  assign req     = rd_en | wr_en;
  assign offset  = sram_offset(address, BASE_ADDR);
  assign req_idx = offset[WORD_IDX_W+1:2];

`ifdef SRAM_RANGE_CHECK_EN
  assign addr_ok = (offset[31:WORD_IDX_W+2] == '0) && (offset[1:0] == 2'b00);
`else
  // Without the check every address wraps into the window, so the bits that
  // would only feed the range test are deliberately dropped.
  logic unused_offset_bits;
  assign addr_ok            = 1'b1;
  assign unused_offset_bits = ^{offset[31:WORD_IDX_W+2], offset[1:0]};
`endif

  assign ready = (state == DONE) || ((state == IDLE) && !req);

  assign cnt_clear = ((state == IDLE) && req && addr_ok) ||
                     ((state == LOW) && cnt_done);
  assign cnt_en    = (state == LOW) || (state == HIGH);

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(cnt_clear),
    .en   (cnt_en),
    .done (cnt_done)
  );

  // Strobes are registered on the edge entering each phase so they are stable
  // for the whole phase; read halves are captured on the edge that ends it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      data_q      <= '0;
      idx_q       <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      addr_err    <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            is_write <= wr_en;
            data_q   <= write_data;
            idx_q    <= req_idx;
            if (addr_ok) begin
              state      <= LOW;
              sram_addr  <= {req_idx, 1'b0};
              sram_we_n  <= !wr_en;
              sram_dq_oe <= wr_en;
              if (wr_en) begin
                sram_dq_out <= write_data[15:0];
              end
            end else begin
              state    <= DONE;
              addr_err <= 1'b1;
              if (!wr_en) begin
                read_data <= '0;
              end
            end
          end
        end
        LOW: begin
          if (cnt_done) begin
            state     <= HIGH;
            sram_addr <= {idx_q, 1'b1};
            if (is_write) begin
              sram_dq_out <= data_q[31:16];
            end else begin
              read_data[15:0] <= sram_dq_in;
            end
          end
        end
        HIGH: begin
          if (cnt_done) begin
            state      <= DONE;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!is_write) begin
              read_data[31:16] <= sram_dq_in;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage bridge between the ARM pipeline's data-memory request (address from the EXE-stage ALU result, store data from Rm) and an external 16-bit asynchronous SRAM. Each 32-bit load or store is split into two sequenced half-word SRAM accesses. `ready` stays low while the access is in flight, and the pipeline uses it to freeze. The block is the responder for the memory requests that the execute stage initiates.

## Interface
- `WAIT_CYCLES`, 2: cycles per half-word SRAM access; legal range 1..15.
- `BASE_ADDR`, 32'd1024: byte address mapped to SRAM word 0.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `rd_en` input 1: load request (MEM_R_EN).
- `wr_en` input 1: store request (MEM_W_EN); has priority over `rd_en`.
- `address` input 32: byte address (ALU result).
- `write_data` input 32: store data (Rm value).
- `read_data` output 32: load data; valid while `ready` is high after a load.
- `ready` output 1: high when no request is pending or the access has completed; the pipeline freezes while it is low.
- `addr_err` output 1: out-of-range pulse; see Configuration.
- `sram_addr` output 18: SRAM half-word address.
- `sram_dq_out` output 16: write data to the SRAM.
- `sram_dq_oe` output 1: drive enable for the DQ pads.
- `sram_dq_in` input 16: read data from the SRAM.
- `sram_we_n` output 1: SRAM write enable, active-low.

## Operation
- States:
  - IDLE: waiting for a request.
  - LOW: accessing the low half-word.
  - HIGH: accessing the high half-word.
  - DONE: one-cycle completion.
- Transitions:
  - IDLE → LOW when `rd_en|wr_en`. On this edge latch the op (write if `wr_en`), `write_data`, and word index `idx = (address - BASE_ADDR) >> 2` (17 bits, wraps modulo 2^17).
  - LOW → HIGH after `WAIT_CYCLES` cycles in LOW.
  - HIGH → DONE after `WAIT_CYCLES` cycles in HIGH.
  - DONE → IDLE unconditionally.
- `sram_addr`:
  - LOW: `{idx,1'b0}`.
  - HIGH: `{idx,1'b1}`.
  - Otherwise: holds the last value.
- Writes:
  - `sram_we_n` = 0 and `sram_dq_oe` = 1 for every cycle of LOW and HIGH.
  - `sram_dq_out` = latched data[15:0] in LOW, data[31:16] in HIGH.
- Reads:
  - `sram_we_n` = 1 and `sram_dq_oe` = 0 throughout.
  - On the last LOW cycle, capture `sram_dq_in` into `read_data[15:0]`.
  - On the last HIGH cycle, capture it into `read_data[31:16]`.
  - A write leaves `read_data` unchanged.
- `ready` (combinational): 1 in DONE; 1 in IDLE when `rd_en|wr_en` = 0; 0 otherwise.
- Request inputs are ignored outside IDLE. A request that drops mid-access does not abort it.
- Request held high across DONE: the next access starts from IDLE on the following cycle. The pipeline advances on the `ready` edge, so the inputs then show the new request.
- Reset (at any time, including mid-access):
  - State → IDLE, `read_data` = 0, `sram_addr` = 0, `sram_dq_out` = 0.
  - `sram_we_n` = 1, `sram_dq_oe` = 0, `addr_err` = 0, `ready` follows the IDLE rule.
  - No partial write is resumed.

## Timing
- Request accepted in cycle 0 (IDLE, `ready` = 0).
- LOW occupies cycles 1..W and HIGH occupies cycles W+1..2W, where W = `WAIT_CYCLES`.
- DONE is cycle 2W+1, with `ready` = 1.
- `ready` is low for 2W+1 consecutive cycles per access. Default W = 2 gives 5 frozen cycles.
- Back-to-back accesses: minimum 2W+2 cycles per access.
- The wait counter is 4 bits. It resets to 0 on entry to LOW and on entry to HIGH.

## Configuration
- Macro: `SRAM_RANGE_CHECK_EN`.
- Defined:
  - An address outside [`BASE_ADDR`, `BASE_ADDR`+2^19) or not 4-byte aligned skips LOW/HIGH. IDLE goes directly to DONE.
  - No SRAM strobes are asserted. `read_data` = 0 for a load.
  - `addr_err` = 1 during that DONE cycle only.
- Not defined: no check is made; the address wraps as described; `addr_err` is tied to 0.

## Structure
- Package `arm_mem_pkg`:
  - State enum (IDLE/LOW/HIGH/DONE).
  - `SRAM_ADDR_W` = 18 and `SRAM_DATA_W` = 16.
  - Default `BASE_ADDR`.
- Sub-module `sram_wait_counter`: a 4-bit counter with `clear`, `en` and `done` (count == `WAIT_CYCLES`-1), reset by `rst_n`. The FSM instantiates it once.

## Test plan
- Store, W=2: `address` = 1032, `write_data` = 0xDEADBEEF.
  - `sram_addr` = 4 with `sram_dq_out` = 0xBEEF for 2 cycles, then `sram_addr` = 5 with 0xDEAD for 2 cycles.
  - `sram_we_n` low for 4 cycles; `ready` low for exactly 5 cycles.
- Load, W=2: the model returns 0x1234 at address 4 and 0xABCD at address 5.
  - Load from 1032 gives `read_data` = 0xABCD1234 with `ready` = 1 in cycle 5; `sram_dq_oe` stays 0.
- Both enables high: `rd_en` = `wr_en` = 1 performs a write; `read_data` keeps its previous value.
- Back-to-back: load then store, with the request held across DONE.
  - The second access begins in the cycle after DONE; the total is 12 cycles.
- Reset mid-write: deassert `rst_n` in HIGH cycle 1.
  - Outputs take reset values immediately (asynchronously): `sram_we_n` = 1, `sram_dq_oe` = 0.
  - After release the block is in IDLE.
- With `SRAM_RANGE_CHECK_EN`: load from `address` = 0x200.
  - `ready` = 1 in cycle 1 with `addr_err` = 1 and `read_data` = 0; no SRAM strobes.
